hw_stack: RTL and testbench

HW_STACK -- requirements
Module: hw_stack

---
 rtl/stack_pkg.sv | 9 +
 rtl/stack_ram.sv | 26 ++
 rtl/hw_stack.sv | 97 +++++++++
 tb/tb_hw_stack.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared stack op encodings, used by hw_stack and the CPU decoder.
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port, two async read ports.
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/hw_stack.sv
// Hardware LIFO stack with PUSH/POP/REPL, synchronous flush and top/next views.
// Define HW_STACK_ERR_EN to build the sticky ovf/unf error registers.
module hw_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          push_ok, pop_ok, repl_ok, we;
    logic [AW-1:0] sp_m1, sp_m2, waddr;
    logic [WIDTH-1:0] rdata0, rdata1;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    assign push_ok = (op == OP_PUSH) && !full;
    assign pop_ok  = (op == OP_POP)  && !empty;
    assign repl_ok = (op == OP_REPL) && (count >= CW'(2));

    // Modulo-DEPTH arithmetic on the low bits is exact whenever the entry exists.
    assign sp_m1 = count[AW-1:0] - AW'(1);
    assign sp_m2 = count[AW-1:0] - AW'(2);
    assign waddr = push_ok ? count[AW-1:0] : sp_m2;
    assign we    = !clr && (push_ok || repl_ok);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (sp_m1),
        .rdata0 (rdata0),
        .raddr1 (sp_m2),
        .rdata1 (rdata1)
    );

    assign top  = (count >= CW'(1)) ? rdata0 : '0;
    assign next = (count >= CW'(2)) ? rdata1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok || repl_ok) begin
            count <= count - CW'(1);
        end
    end

`ifdef HW_STACK_ERR_EN
    logic ovf_set, unf_set;

    assign ovf_set = (op == OP_PUSH) && full;
    assign unf_set = ((op == OP_POP) && empty) ||
                     ((op == OP_REPL) && (count < CW'(2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set) ovf <= 1'b1;
            if (unf_set) unf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack: directed scenarios plus random ops vs a queue model.
module tb_hw_stack;
    import stack_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk, rst_n, clr;
    logic [1:0]        op;
    logic [WIDTH-1:0]  wdata, top, next;
    logic [2:0]        count;
    logic              full, empty, ovf, unf;

    hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .op    (op),
        .wdata (wdata),
        .top   (top),
        .next  (next),
        .count (count),
        .full  (full),
        .empty (empty),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [WIDTH-1:0] mq[$];
    logic m_ovf, m_unf;

`ifdef HW_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".top"},   64'(top),   (n >= 1) ? 64'(mq[n-1]) : 64'd0);
        chk({tag, ".next"},  64'(next),  (n >= 2) ? 64'(mq[n-2]) : 64'd0);
        chk({tag, ".full"},  64'(full),  64'(n == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".ovf"},   64'(ovf),   64'(m_ovf & ERR_EN));
        chk({tag, ".unf"},   64'(unf),   64'(m_unf & ERR_EN));
    endtask

    // Reference behaviour: a plain queue whose back is the top of stack.
    task automatic model_apply(input logic [1:0] o, input logic [WIDTH-1:0] d, input logic c);
        logic [WIDTH-1:0] tmp;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            case (o)
                OP_PUSH: if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1'b1;
                OP_POP:  if (mq.size() >= 1) tmp = mq.pop_back(); else m_unf = 1'b1;
                OP_REPL: if (mq.size() >= 2) begin
                             tmp = mq.pop_back();
                             tmp = mq.pop_back();
                             mq.push_back(d);
                         end else m_unf = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d,
                         input logic c);
        @(negedge clk);
        op = o; wdata = d; clr = c;
        @(posedge clk);
        model_apply(o, d, c);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Async reset between edges, then release with an op already on the inputs.
    task automatic mid_reset(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(negedge clk);
        op = o; wdata = d; clr = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_apply(o, d, 1'b0);
        #1;
        check_all({tag, ".release"});
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; op = OP_NOP; wdata = '0;
        model_reset();
        #1;
        check_all("reset0");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, overflow, replace, underflow scenarios
        do_op("push11", OP_PUSH, 32'h11, 1'b0);
        do_op("push22", OP_PUSH, 32'h22, 1'b0);
        do_op("push33", OP_PUSH, 32'h33, 1'b0);
        do_op("repl55", OP_REPL, 32'h55, 1'b0);
        do_op("push33b", OP_PUSH, 32'h33, 1'b0);
        do_op("push44", OP_PUSH, 32'h44, 1'b0);
        do_op("push_full", OP_PUSH, 32'h55, 1'b0);
        do_op("nop_full", OP_NOP, 32'hdead, 1'b0);
        do_op("pop1", OP_POP, 32'h0, 1'b0);
        do_op("pop2", OP_POP, 32'h0, 1'b0);
        do_op("clr_push", OP_PUSH, 32'h99, 1'b1);
        do_op("pop_empty", OP_POP, 32'h0, 1'b0);
        do_op("push_one", OP_PUSH, 32'h77, 1'b0);
        do_op("repl_cnt1", OP_REPL, 32'h88, 1'b0);
        do_op("push_two", OP_PUSH, 32'h66, 1'b0);
        do_op("push_three", OP_PUSH, 32'h65, 1'b0);
        mid_reset("rst_mid", OP_PUSH, 32'hab);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] o;
            logic c;
            o = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0)
                mid_reset($sformatf("rnd_rst%0d", i), o, $urandom);
            else
                do_op($sformatf("rnd%0d", i), o, $urandom, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
